// File: rtl/id_ex_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// Optional feature macro: LOAD_USE_DETECT_EN (load-use hazard output).
package id_ex_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;
    localparam int BCNT_W     = 16;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'h7;

    typedef struct packed {
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                reg_dst;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // A bubble must never carry a side effect into EX.
    function automatic ctrl_t mask_side_effects(input ctrl_t c, input logic valid);
        ctrl_t r;
        r           = c;
        r.reg_write = c.reg_write & valid;
        r.mem_read  = c.mem_read  & valid;
        r.mem_write = c.mem_write & valid;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID -> EX bus: ID-side fields, registered EX-side copies and status.
// load_use exists only when LOAD_USE_DETECT_EN is defined.
interface id_ex_reg_if
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic                  stall;
    logic                  flush;

    logic                  id_valid;
    logic [DATA_W-1:0]     id_rd1, id_rd2, id_imm, id_pc4;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic                  id_alu_src, id_reg_dst, id_reg_write;
    logic                  id_mem_read, id_mem_write, id_mem_to_reg;
    logic [ALU_OP_W-1:0]   id_alu_op;

    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic                  ex_alu_src, ex_reg_dst, ex_reg_write;
    logic                  ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [ALU_OP_W-1:0]   ex_alu_op;

    logic [BCNT_W-1:0]     bubble_cnt;
`ifdef LOAD_USE_DETECT_EN
    logic                  load_use;
`endif

    modport master (
        output stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_pc4,
               id_rs, id_rt, id_rd, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_alu_op,
        input  ex_valid, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
               ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_op, bubble_cnt
`ifdef LOAD_USE_DETECT_EN
        , input load_use
`endif
    );

    modport slave (
        input  stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_pc4,
               id_rs, id_rt, id_rd, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_alu_op,
        output ex_valid, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
               ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_op, bubble_cnt
`ifdef LOAD_USE_DETECT_EN
        , output load_use
`endif
    );

endinterface

// File: rtl/id_ex_reg_pipe_field_reg.sv
// One field group of the ID/EX register: reset/flush clear to zero,
// stall holds, otherwise loads. Reset beats flush beats stall.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_stall,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Held value never looks at i_d, so garbage on i_d during stall is harmless.
    always_ff @(posedge clk) begin
        if (rst)           r_q <= '0;
        else if (i_flush)  r_q <= '0;
        else if (!i_stall) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble counter.
// Optional macro LOAD_USE_DETECT_EN adds the combinational load_use output.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_reg_if.slave  bus
);
    localparam int DGRP_W = 4 * DATA_W;
    localparam int RGRP_W = 3 * REG_ADDR_W;

    logic [DGRP_W-1:0] w_data_d, w_data_q;
    logic [RGRP_W-1:0] w_regs_d, w_regs_q;
    ctrl_t             w_ctrl_raw, w_ctrl_d, w_ctrl_q;
    logic              w_valid_q;
    logic              w_bubble;
    logic [BCNT_W-1:0] r_bubble_cnt;

    assign w_data_d = {bus.id_rd1, bus.id_rd2, bus.id_imm, bus.id_pc4};
    assign w_regs_d = {bus.id_rs, bus.id_rt, bus.id_rd};

    // Pack ID controls; side-effect bits are gated by id_valid before registering.
    always_comb begin
        w_ctrl_raw            = '0;
        w_ctrl_raw.alu_src    = bus.id_alu_src;
        w_ctrl_raw.alu_op     = bus.id_alu_op;
        w_ctrl_raw.reg_dst    = bus.id_reg_dst;
        w_ctrl_raw.reg_write  = bus.id_reg_write;
        w_ctrl_raw.mem_read   = bus.id_mem_read;
        w_ctrl_raw.mem_write  = bus.id_mem_write;
        w_ctrl_raw.mem_to_reg = bus.id_mem_to_reg;
        w_ctrl_d              = mask_side_effects(w_ctrl_raw, bus.id_valid);
    end

    pipe_field_reg #(.W(DGRP_W)) u_data (
        .clk(clk), .rst(rst), .i_flush(bus.flush), .i_stall(bus.stall),
        .i_d(w_data_d), .o_q(w_data_q)
    );

    pipe_field_reg #(.W(RGRP_W)) u_regs (
        .clk(clk), .rst(rst), .i_flush(bus.flush), .i_stall(bus.stall),
        .i_d(w_regs_d), .o_q(w_regs_q)
    );

    pipe_field_reg #(.W(CTRL_W + 1)) u_ctrl (
        .clk(clk), .rst(rst), .i_flush(bus.flush), .i_stall(bus.stall),
        .i_d({bus.id_valid, w_ctrl_d}), .o_q({w_valid_q, w_ctrl_q})
    );

    assign {bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_pc4} = w_data_q;
    assign {bus.ex_rs, bus.ex_rt, bus.ex_rd}                = w_regs_q;
    assign bus.ex_valid      = w_valid_q;
    assign bus.ex_alu_src    = w_ctrl_q.alu_src;
    assign bus.ex_alu_op     = w_ctrl_q.alu_op;
    assign bus.ex_reg_dst    = w_ctrl_q.reg_dst;
    assign bus.ex_reg_write  = w_ctrl_q.reg_write;
    assign bus.ex_mem_read   = w_ctrl_q.mem_read;
    assign bus.ex_mem_write  = w_ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = w_ctrl_q.mem_to_reg;

    // A bubble enters EX on a flush, or when ID advances with nothing in it.
    assign w_bubble = bus.flush | (~bus.stall & ~bus.id_valid);

    // Saturating bubble counter; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            r_bubble_cnt <= '0;
        else if (w_bubble && (r_bubble_cnt != {BCNT_W{1'b1}}))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end

    assign bus.bubble_cnt = r_bubble_cnt;

`ifdef LOAD_USE_DETECT_EN
    assign bus.load_use = bus.ex_valid & bus.ex_mem_read & (bus.ex_rt != '0) &
                          ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
`else
    // No hazard detection in this build; EX consumers must not expect load_use.
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a reference model predicts the EX view
// after every edge; an independent monitor pops and compares.
module tb_id_ex_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_reg_if #(.DATA_W(32)) bus ();

    id_ex_reg #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        v;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic        asrc;
        logic [3:0]  aop;
        logic        rdst, rw, mr, mw, m2r;
        logic [15:0] bc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: what EX must hold after each edge.
    initial begin
        exp_t        cur;
        int unsigned bc;
        cur = '0;
        bc  = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                cur = '0;
                bc  = 0;
            end else if (bus.flush) begin
                cur = '0;
                if (bc < 65535) bc++;
            end else if (!bus.stall) begin
                cur.v    = bus.id_valid;
                cur.rd1  = bus.id_rd1;  cur.rd2 = bus.id_rd2;
                cur.imm  = bus.id_imm;  cur.pc4 = bus.id_pc4;
                cur.rs   = bus.id_rs;   cur.rt  = bus.id_rt;  cur.rd = bus.id_rd;
                cur.asrc = bus.id_alu_src;
                cur.aop  = bus.id_alu_op;
                cur.rdst = bus.id_reg_dst;
                cur.m2r  = bus.id_mem_to_reg;
                cur.rw   = bus.id_valid ? bus.id_reg_write : 1'b0;
                cur.mr   = bus.id_valid ? bus.id_mem_read  : 1'b0;
                cur.mw   = bus.id_valid ? bus.id_mem_write : 1'b0;
                if (!bus.id_valid && bc < 65535) bc++;
            end
            cur.bc = bc[15:0];
            q.push_back(cur);
        end
    end

    // Monitor: EX outputs are sampled shortly after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", 64'(bus.ex_valid), 64'(e.v));
                chk("ex_rd1",   64'(bus.ex_rd1),   64'(e.rd1));
                chk("ex_rd2",   64'(bus.ex_rd2),   64'(e.rd2));
                chk("ex_imm",   64'(bus.ex_imm),   64'(e.imm));
                chk("ex_pc4",   64'(bus.ex_pc4),   64'(e.pc4));
                chk("ex_regs",  64'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 64'({e.rs, e.rt, e.rd}));
                chk("ex_ctrl",  64'({bus.ex_alu_src, bus.ex_alu_op, bus.ex_reg_dst, bus.ex_reg_write,
                                     bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
                                64'({e.asrc, e.aop, e.rdst, e.rw, e.mr, e.mw, e.m2r}));
                chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(e.bc));
`ifdef LOAD_USE_DETECT_EN
                chk("load_use", 64'(bus.load_use),
                    64'(e.v && e.mr && e.rt != 5'd0 && (e.rt == bus.id_rs || e.rt == bus.id_rt)));
`endif
            end
        end
    end

    task automatic idle();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0; bus.id_pc4 = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_alu_src = 1'b0; bus.id_reg_dst = 1'b0; bus.id_reg_write = 1'b0;
        bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0; bus.id_mem_to_reg = 1'b0;
        bus.id_alu_op = '0;
    endtask

    task automatic rand_id();
        bus.id_valid = ($urandom_range(0, 3) != 0);
        bus.id_rd1 = $urandom; bus.id_rd2 = $urandom;
        bus.id_imm = $urandom; bus.id_pc4 = $urandom;
        bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom); bus.id_rd = 5'($urandom);
        bus.id_alu_src = 1'($urandom); bus.id_reg_dst = 1'($urandom);
        bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
        bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
        bus.id_alu_op = 4'($urandom);
    endtask

    task automatic step(); @(negedge clk); endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // Pass-through: ALU operand mux fields.
        bus.id_valid = 1'b1; bus.id_rd2 = 32'd30; bus.id_imm = 32'd0; bus.id_alu_src = 1'b1;
        step();

        // Stall hold: 5 loaded, 9 presented while stalled for 3 cycles.
        bus.id_rd1 = 32'd5; bus.id_alu_src = 1'b0;
        step();
        bus.id_rd1 = 32'd9; bus.stall = 1'b1;
        step(); step(); step();
        bus.stall = 1'b0;
        step();

        // Flush together with stall on a writing instruction.
        bus.id_reg_write = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        step();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.id_reg_write = 1'b0;
        step();

        // Reset in the middle of a stall.
        bus.id_rd2 = 32'd7;
        step();
        bus.stall = 1'b1; bus.id_rd2 = 32'd99;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.stall = 1'b0; bus.id_rd2 = 32'd11;
        step();

`ifdef LOAD_USE_DETECT_EN
        // Load into r8, consumer reads r8; then the same with rt = r0.
        idle();
        bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_rt = 5'd8;
        step();
        bus.id_mem_read = 1'b0; bus.id_rt = 5'd1; bus.id_rs = 5'd8;
        #2 chk("load_use_hit", 64'(bus.load_use), 64'd1);
        step();
        bus.id_mem_read = 1'b1; bus.id_rt = 5'd0; bus.id_rs = 5'd0;
        step();
        #2 chk("load_use_r0", 64'(bus.load_use), 64'd0);
        step();
`endif

        // Random mix of stall, flush, bubbles and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        // Saturation: clear, 65535 flushes, then one more.
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.flush = 1'b1;
        repeat (65535) step();
        chk("bubble_sat", 64'(bus.bubble_cnt), 64'hFFFF);
        step();
        chk("bubble_sat_hold", 64'(bus.bubble_cnt), 64'hFFFF);
        bus.flush = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of all data fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hold current contents (EX not ready).
REQ-005 flush  input  1  insert bubble (branch taken / load-use).
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_rd1, id_rd2, id_imm, id_pc4  input  DATA_W each  register-file reads, sign-extended immediate, PC+4.
REQ-008 id_rs, id_rt, id_rd  input  5 each  register numbers.
REQ-009 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  control bits.
REQ-010 id_alu_op  input  4  ALU operation code.
REQ-011 ex_* outputs  output  same widths  registered copies of every id_* input, plus ex_valid.
REQ-012 ex_alu_src drives the select of the downstream 2:1 ALU-operand mux; ex_rd2 and ex_imm drive its data inputs 0 and 1.
REQ-013 bubble_cnt  output  16  saturating count of bubbles inserted.
REQ-014 load_use  output  1  present only with LOAD_USE_DETECT_EN.

Function
REQ-015 Normal (no stall, no flush): every ex_* register loads its id_* counterpart each edge; latency exactly 1 cycle; ex_valid <= id_valid.
REQ-016 Stall=1, flush=0: all ex_* registers hold; bubble_cnt holds.
REQ-017 Flush=1 (regardless of stall): ex_valid, ex_reg_write, ex_mem_read, ex_mem_write cleared; data fields and remaining control bits don't-care but shall load 0.
REQ-018 Flush has priority over stall on simultaneous assertion.
REQ-019 bubble_cnt increments by 1 on every edge where flush=1, or where stall=0 and id_valid=0; saturates at 16'hFFFF, never wraps.
REQ-020 Any ex_* side-effect bit (reg_write, mem_read, mem_write) shall be 0 whenever ex_valid=0.
REQ-021 No combinational path from any input to any ex_* output; load_use is the only combinational output.
REQ-022 id_* inputs at X while stall=1 shall not corrupt held state.

Reset
REQ-023 rst=1 at an edge overrides stall and flush: all ex_* outputs 0, ex_valid 0, bubble_cnt 0.
REQ-024 rst asserted mid-stall discards the held instruction; first edge after rst deasserts behaves as REQ-015.

Configuration
REQ-025 Macro LOAD_USE_DETECT_EN: when defined, load_use = ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt); port present.
REQ-026 When undefined: load_use port and its logic absent; all other behaviour identical.

Structure
REQ-027 Shared package holds: DATA_W default, REG_ADDR_W=5, ALU_OP_W=4, ALU-op code constants, and a control-bundle struct type (alu_src, alu_op, reg_dst, reg_write, mem_read, mem_write, mem_to_reg).
REQ-028 One sub-module, pipe_field_reg: parameterised-width register with rst/flush-clear/stall-hold, instantiated per field group (data, register numbers, control).

Verification
REQ-029 Pass-through: rst then id_rd2=30, id_imm=0, id_alu_src=1, id_valid=1 -> next cycle ex_rd2=30, ex_imm=0, ex_alu_src=1, ex_valid=1.
REQ-030 Stall hold: load id_rd1=5, assert stall 3 cycles while id_rd1=9 -> ex_rd1 stays 5 for 3 cycles, becomes 9 one cycle after stall drops; bubble_cnt unchanged.
REQ-031 Flush+stall together with id_reg_write=1, id_valid=1 -> ex_valid=0, ex_reg_write=0, bubble_cnt +1.
REQ-032 Saturation: preload via 65 535 flush cycles -> bubble_cnt=16'hFFFF, one further flush keeps 16'hFFFF.
REQ-033 Reset mid-stall: stall=1 holding ex_rd2=7, pulse rst -> ex_rd2=0, ex_valid=0, bubble_cnt=0 next cycle.
REQ-034 LOAD_USE_DETECT_EN: ex_mem_read=1, ex_rt=8, ex_valid=1, id_rs=8 -> load_use=1 same cycle; ex_rt=0 -> load_use=0.
